// File: rtl/pwm_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_ctrl_pkg : shared widths, FSM state codes and duty step helper    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pwm_ctrl_pkg;

  localparam int c_DUTY_W = 8;
  localparam int c_CNT_W  = 10;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_RAMP  = 3'd1;
  localparam logic [2:0] c_ST_BRAKE = 3'd2;
  localparam logic [2:0] c_ST_DEAD  = 3'd3;
  localparam logic [2:0] c_ST_ESTOP = 3'd4;

  // One saturating step from cur toward tgt; 9-bit math so cur+step cannot wrap.
  function automatic logic [c_DUTY_W-1:0] step_toward(
    input logic [c_DUTY_W-1:0] cur,
    input logic [c_DUTY_W-1:0] tgt,
    input logic [c_DUTY_W-1:0] step
  );
    logic [c_DUTY_W:0] w_sum;
    logic [c_DUTY_W:0] w_lim;
    w_sum = {1'b0, cur} + {1'b0, step};
    w_lim = {1'b0, tgt} + {1'b0, step};
    if (cur < tgt)
      step_toward = (w_sum >= {1'b0, tgt}) ? tgt : w_sum[c_DUTY_W-1:0];
    else if ({1'b0, cur} <= w_lim)
      step_toward = tgt;
    else
      step_toward = cur - step;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_period_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_period_tick : PWM period-end detect and ramp-step prescaler       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pwm_period_tick
  import pwm_ctrl_pkg::*;
#(
  parameter int RAMP_DIV   = 8,
  parameter int PERIOD_MAX = 1023
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [c_CNT_W-1:0] i_pwm_counter,
  input  logic               i_clr,
  output logic               o_tick,
  output logic               o_step_en
);

  localparam int              c_PW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(RAMP_DIV - 1);

  logic [c_PW-1:0] r_presc;

  assign o_tick    = (i_pwm_counter == c_CNT_W'(PERIOD_MAX));
  assign o_step_en = o_tick & (r_presc == c_PRE_LAST);

  // Clear beats a coincident tick so a freshly entered ramp waits a full RAMP_DIV periods.
  always_ff @(posedge clk) begin
    if (!arst || i_clr)
      r_presc <= '0;
    else if (o_tick)
      r_presc <= (r_presc == c_PRE_LAST) ? '0 : r_presc + c_PW'(1);
  end

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_ramp_ctrl : slew-limited duty/direction sequencer with estop      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int STEP         = 4,
  parameter int RAMP_DIV     = 8,
  parameter int DEAD_PERIODS = 16,
  parameter int PERIOD_MAX   = 1023
) (
  input  logic                clk,
  input  logic                arst,
  input  logic [c_CNT_W-1:0]  i_pwm_counter,
  input  logic                i_estop,
  input  logic                i_tgt_valid,
  input  logic [c_DUTY_W-1:0] i_tgt_duty,
  input  logic                i_tgt_dir,
  output logic                o_tgt_ready,
  output logic [c_DUTY_W-1:0] o_duty_cycle,
  output logic                o_dir,
  output logic                o_motor_en,
  output logic                o_at_target,
  output logic [2:0]          o_state
);

  localparam int                  c_DW        = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam logic [c_DUTY_W-1:0] c_STEP      = c_DUTY_W'(STEP);
  localparam logic [c_DW-1:0]     c_DEAD_LAST = c_DW'(DEAD_PERIODS - 1);

  logic [2:0]          r_state,  w_state_n;
  logic [c_DUTY_W-1:0] r_duty,   w_duty_n;
  logic                r_dir,    w_dir_n;
  logic                r_motor_en;
  logic [c_DUTY_W-1:0] r_tgt_d,  w_tgt_d_n;
  logic                r_tgt_r,  w_tgt_r_n;
  logic [c_DW-1:0]     r_dead,   w_dead_n;
  logic                w_acc, w_clr, w_tick, w_step_en, w_motor_en_n;

  pwm_period_tick #(
    .RAMP_DIV   (RAMP_DIV),
    .PERIOD_MAX (PERIOD_MAX)
  ) u_tick (
    .clk           (clk),
    .arst          (arst),
    .i_pwm_counter (i_pwm_counter),
    .i_clr         (w_clr),
    .o_tick        (w_tick),
    .o_step_en     (w_step_en)
  );

  assign o_tgt_ready  = ((r_state == c_ST_IDLE) || (r_state == c_ST_RAMP)) & ~i_estop & arst;
  assign w_acc        = i_tgt_valid & o_tgt_ready;
  assign o_duty_cycle = r_duty;
  assign o_dir        = r_dir;
  assign o_motor_en   = r_motor_en;
  assign o_at_target  = (r_state == c_ST_IDLE) && (r_duty == r_tgt_d);
  assign o_state      = r_state;

  always_comb begin
    w_state_n = r_state;
    w_duty_n  = r_duty;
    w_dir_n   = r_dir;
    w_tgt_d_n = r_tgt_d;
    w_tgt_r_n = r_tgt_r;
    w_dead_n  = r_dead;
    w_clr     = 1'b0;
    if (w_acc) begin
      w_tgt_d_n = i_tgt_duty;
      w_tgt_r_n = i_tgt_dir;
    end
    if (i_estop) begin
      w_state_n = c_ST_ESTOP;
      w_duty_n  = '0;
      w_tgt_d_n = '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_acc) begin
            if (i_tgt_dir != r_dir) begin
              if (r_duty != '0) begin
                w_state_n = c_ST_BRAKE;
                w_clr     = 1'b1;
              end else begin
                w_state_n = c_ST_DEAD;
                w_dead_n  = '0;
              end
            end else if (i_tgt_duty != r_duty) begin
              w_state_n = c_ST_RAMP;
              w_clr     = 1'b1;
            end
          end
        end
        c_ST_RAMP: begin
          if (w_acc && (i_tgt_dir != r_dir)) begin
            w_state_n = c_ST_BRAKE;
            w_clr     = 1'b1;
          end else begin
            // A step coinciding with an accept still aims at the old target.
            if (w_step_en)
              w_duty_n = step_toward(r_duty, r_tgt_d, c_STEP);
            if (!w_acc && (w_duty_n == r_tgt_d))
              w_state_n = c_ST_IDLE;
          end
        end
        c_ST_BRAKE: begin
          if (w_step_en)
            w_duty_n = step_toward(r_duty, '0, c_STEP);
          if (w_duty_n == '0) begin
            w_state_n = c_ST_DEAD;
            w_dead_n  = '0;
          end
        end
        c_ST_DEAD: begin
          w_duty_n = '0;
          if (w_tick) begin
            if (r_dead == c_DEAD_LAST) begin
              w_dir_n  = r_tgt_r;
              w_dead_n = '0;
              if (r_tgt_d != '0) begin
                w_state_n = c_ST_RAMP;
                w_clr     = 1'b1;
              end else begin
                w_state_n = c_ST_IDLE;
              end
            end else begin
              w_dead_n = r_dead + c_DW'(1);
            end
          end
        end
        c_ST_ESTOP: w_state_n = c_ST_IDLE;
        default:    w_state_n = c_ST_IDLE;
      endcase
    end
  end

  assign w_motor_en_n = ((w_state_n == c_ST_IDLE) || (w_state_n == c_ST_RAMP)) && (w_duty_n != '0);

  always_ff @(posedge clk) begin
    if (!arst) begin
      r_state    <= c_ST_IDLE;
      r_duty     <= '0;
      r_dir      <= 1'b0;
      r_motor_en <= 1'b0;
      r_tgt_d    <= '0;
      r_tgt_r    <= 1'b0;
      r_dead     <= '0;
    end else begin
      r_state    <= w_state_n;
      r_duty     <= w_duty_n;
      r_dir      <= w_dir_n;
      r_motor_en <= w_motor_en_n;
      r_tgt_d    <= w_tgt_d_n;
      r_tgt_r    <= w_tgt_r_n;
      r_dead     <= w_dead_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pwm_ramp_ctrl : self-checking bench with behavioural model         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_pwm_ramp_ctrl;
  import pwm_ctrl_pkg::*;

  localparam int STEP         = 4;
  localparam int RAMP_DIV     = 2;
  localparam int DEAD_PERIODS = 3;
  localparam int PERIOD_MAX   = 1023;

  logic       clk   = 1'b0;
  logic       arst  = 1'b0;
  logic [9:0] cnt   = 10'd31;
  logic       estop = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] tduty = 8'd0;
  logic       tdir  = 1'b0;

  logic       o_tgt_ready, o_dir, o_motor_en, o_at_target;
  logic [7:0] o_duty;
  logic [2:0] o_state;

  int n_pass  = 0;
  int n_total = 0;

  // behavioural model state
  bit         m_live = 1'b0;
  logic [2:0] m_mode = c_ST_IDLE;
  int         m_duty, m_dir, m_tgt_d, m_tgt_r, m_pcount, m_dcount;
  int         q_seen[$];

  pwm_ramp_ctrl #(
    .STEP         (STEP),
    .RAMP_DIV     (RAMP_DIV),
    .DEAD_PERIODS (DEAD_PERIODS),
    .PERIOD_MAX   (PERIOD_MAX)
  ) dut (
    .clk           (clk),
    .arst          (arst),
    .i_pwm_counter (cnt),
    .i_estop       (estop),
    .i_tgt_valid   (valid),
    .i_tgt_duty    (tduty),
    .i_tgt_dir     (tdir),
    .o_tgt_ready   (o_tgt_ready),
    .o_duty_cycle  (o_duty),
    .o_dir         (o_dir),
    .o_motor_en    (o_motor_en),
    .o_at_target   (o_at_target),
    .o_state       (o_state)
  );

  always #5 clk = ~clk;

  // 10-bit wrapping counter with a stride of 32: one PWM period every 32 clocks
  always @(posedge clk) cnt <= cnt + 10'd32;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic bit exp_ready();
    return ((m_mode == c_ST_IDLE) || (m_mode == c_ST_RAMP)) && !estop && arst;
  endfunction

  task automatic model_step();
    bit tick, acc;
    int old_t;
    tick = (cnt == 10'(PERIOD_MAX));
    acc  = valid && exp_ready();
    if (!arst) begin
      m_live = 1'b1; m_mode = c_ST_IDLE; m_duty = 0; m_dir = 0;
      m_tgt_d = 0; m_tgt_r = 0; m_pcount = 0; m_dcount = 0;
      return;
    end
    if (estop) begin
      m_mode = c_ST_ESTOP; m_duty = 0; m_tgt_d = 0;
      return;
    end
    old_t = m_tgt_d;
    if (acc) begin m_tgt_d = int'(tduty); m_tgt_r = int'(tdir); end
    case (m_mode)
      c_ST_IDLE: if (acc) begin
        if (int'(tdir) != m_dir) begin
          if (m_duty != 0) begin m_mode = c_ST_BRAKE; m_pcount = 0; end
          else begin m_mode = c_ST_DEAD; m_dcount = 0; end
        end else if (int'(tduty) != m_duty) begin
          m_mode = c_ST_RAMP; m_pcount = 0;
        end
      end
      c_ST_RAMP: begin
        if (acc && int'(tdir) != m_dir) begin
          m_mode = c_ST_BRAKE; m_pcount = 0;
        end else begin
          if (tick) begin
            m_pcount++;
            if (m_pcount % RAMP_DIV == 0)
              m_duty = (m_duty < old_t) ? ((m_duty + STEP > old_t) ? old_t : m_duty + STEP)
                                        : ((m_duty - STEP < old_t) ? old_t : m_duty - STEP);
          end
          if (!acc && m_duty == old_t) m_mode = c_ST_IDLE;
        end
      end
      c_ST_BRAKE: begin
        if (tick) begin
          m_pcount++;
          if (m_pcount % RAMP_DIV == 0) m_duty = (m_duty < STEP) ? 0 : m_duty - STEP;
        end
        if (m_duty == 0) begin m_mode = c_ST_DEAD; m_dcount = 0; end
      end
      c_ST_DEAD: if (tick) begin
        m_dcount++;
        if (m_dcount == DEAD_PERIODS) begin
          m_dir = m_tgt_r;
          if (m_tgt_d != 0) begin m_mode = c_ST_RAMP; m_pcount = 0; end
          else m_mode = c_ST_IDLE;
        end
      end
      default: m_mode = c_ST_IDLE;
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("duty", int'(o_duty), m_duty);
      chk("dir", int'(o_dir), m_dir);
      chk("motor_en", int'(o_motor_en),
          int'(((m_mode == c_ST_IDLE) || (m_mode == c_ST_RAMP)) && m_duty != 0));
      chk("at_target", int'(o_at_target), int'(m_mode == c_ST_IDLE && m_duty == m_tgt_d));
      chk("tgt_ready", int'(o_tgt_ready), int'(exp_ready()));
      chk("state", int'(o_state), int'(m_mode));
    end
  end

  task automatic send(input int d, input bit r);
    valid = 1'b1; tduty = 8'(d); tdir = r;
    chk("ready_at_send", int'(o_tgt_ready), 1);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic collect(input int max_cyc);
    int last, n;
    q_seen.delete();
    last = int'(o_duty);
    n = 0;
    while (n < max_cyc) begin
      if (int'(o_duty) != last) begin q_seen.push_back(int'(o_duty)); last = int'(o_duty); end
      if (o_at_target) break;
      @(posedge clk); #1;
      n++;
    end
    chk("collect_timeout", int'(n < max_cyc), 1);
  endtask

  task automatic check_seq(input string nm, input int n, input int a, input int b,
                           input int c, input int d);
    int e[4];
    e = '{a, b, c, d};
    chk({nm, "_len"}, q_seen.size(), n);
    for (int k = 0; k < n && k < q_seen.size(); k++) chk(nm, q_seen[k], e[k]);
  endtask

  initial begin
    int n;
    // reset held five clocks
    arst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_duty", int'(o_duty), 0);
    chk("rst_dir", int'(o_dir), 0);
    chk("rst_motor_en", int'(o_motor_en), 0);
    chk("rst_ready", int'(o_tgt_ready), 0);
    arst = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", int'(o_tgt_ready), 1);
    chk("rel_state", int'(o_state), int'(c_ST_IDLE));

    send(10, 1'b0); collect(2000);
    check_seq("ramp_up", 3, 4, 8, 10, 0);
    chk("ramp_up_idle", int'(o_state), int'(c_ST_IDLE));

    send(1, 1'b0); collect(2000);
    check_seq("ramp_down", 3, 6, 2, 1, 0);

    send(8, 1'b0); collect(2000);
    check_seq("ramp_to8", 2, 5, 8, 0, 0);

    send(8, 1'b1); collect(3000);
    check_seq("reversal", 4, 4, 0, 4, 8);
    chk("reversal_dir", int'(o_dir), 1);

    send(10, 1'b1); collect(2000);
    check_seq("to10", 1, 10, 0, 0, 0);

    // estop while ramping down through 6
    send(0, 1'b1);
    n = 0;
    while (o_duty != 8'd6 && n < 500) begin @(posedge clk); #1; n++; end
    chk("reach6", int'(o_duty), 6);
    estop = 1'b1;
    @(posedge clk); #1;
    chk("estop_duty", int'(o_duty), 0);
    chk("estop_motor_en", int'(o_motor_en), 0);
    chk("estop_ready", int'(o_tgt_ready), 0);
    chk("estop_state", int'(o_state), int'(c_ST_ESTOP));
    repeat (2) @(posedge clk);
    #1;
    estop = 1'b0;
    @(posedge clk); #1;
    chk("estop_exit_state", int'(o_state), int'(c_ST_IDLE));
    chk("estop_exit_at_target", int'(o_at_target), 1);

    // retarget on the very cycle of a step
    send(8, 1'b1);
    n = 0;
    while (o_duty != 8'd4 && n < 500) begin @(posedge clk); #1; n++; end
    chk("reach4", int'(o_duty), 4);
    n = 0;
    while (!(cnt == 10'(PERIOD_MAX) && ((m_pcount + 1) % RAMP_DIV == 0)) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk("collide_found", int'(n < 500), 1);
    send(20, 1'b1);
    chk("collide_duty", int'(o_duty), 8);
    chk("collide_state", int'(o_state), int'(c_ST_RAMP));
    collect(2000);
    check_seq("collide_next", 3, 12, 16, 20, 0);

    // randomized traffic
    for (int i = 0; i < 14000; i++) begin
      valid = ($urandom_range(0, 199) == 0);
      tduty = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom);
      tdir  = 1'($urandom_range(0, 1));
      if (estop) estop = ($urandom_range(0, 3) != 0);
      else       estop = ($urandom_range(0, 2499) == 0);
      if (!arst) arst = 1'b1;
      else if ($urandom_range(0, 4999) == 0) arst = 1'b0;
      @(posedge clk); #1;
    end
    valid = 1'b0; estop = 1'b0; arst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
